// File: rtl/mult_arbiter_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter slice.
package mult_arb_types;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned CNT_W_DEF   = $clog2(TIMEOUT_DEF);

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after i_ptr wins.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(off);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among NUM_REQ requesters.
module mult_arbiter
    import mult_arb_types::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   multiplicand_i,
    input  logic [NUM_REQ*WIDTH-1:0]   multiplier_i,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [NUM_REQ-1:0]         resp_err,
    output logic [2*WIDTH-1:0]         product_o,
    output logic                       busy,
    input  logic                       m_rdy,
    output logic                       m_start,
    output logic [WIDTH-1:0]           m_multiplicand,
    output logic [WIDTH-1:0]           m_multiplier,
    input  logic                       m_done,
    input  logic [2*WIDTH-1:0]         m_product
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    arb_state_t r_state, w_state_nxt;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_win_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt, r_resp_valid, r_resp_err;
    logic [2*WIDTH-1:0] r_product;
    logic               r_busy, r_m_start;
    logic [WIDTH-1:0]   r_m_mcand, r_m_mplier;

    logic [NUM_REQ-1:0] w_pick_oh, w_win_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any_req, w_arb, w_timeout;
    logic [WIDTH-1:0]   w_mcand, w_mplier;
    logic [NUM_REQ-1:0] w_gnt_nxt, w_valid_nxt, w_err_nxt;
    logic               w_start_nxt, w_busy_nxt;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_any_req)
    );

    assign w_arb     = (r_state == IDLE) && w_any_req && m_rdy;
    // The ISSUE cycle counts as the first waiting cycle, so an abort lands TIMEOUT cycles after m_start.
    assign w_timeout = (r_state == WAIT) && !m_done && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_win_oh  = NUM_REQ'(1) << r_win_idx;

    always_comb begin
        w_mcand  = '0;
        w_mplier = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_mcand  = multiplicand_i[i*WIDTH +: WIDTH];
                w_mplier = multiplier_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (m_done || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt   = '0;
        w_valid_nxt = '0;
        w_err_nxt   = '0;
        w_start_nxt = 1'b0;
        w_busy_nxt  = (w_state_nxt != IDLE);
        if (w_arb) begin
            w_gnt_nxt   = w_pick_oh;
            w_start_nxt = 1'b1;
        end
        if (r_state == WAIT && m_done) begin
            w_valid_nxt = w_win_oh;
        end
        if (w_timeout) begin
            w_err_nxt = w_win_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_win_idx    <= '0;
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= '0;
            r_product    <= '0;
            r_busy       <= 1'b0;
            r_m_start    <= 1'b0;
            r_m_mcand    <= '0;
            r_m_mplier   <= '0;
        end else begin
            r_gnt        <= w_gnt_nxt;
            r_resp_valid <= w_valid_nxt;
            r_resp_err   <= w_err_nxt;
            r_m_start    <= w_start_nxt;
            r_busy       <= w_busy_nxt;
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_win_idx  <= w_pick_idx;
                        r_m_mcand  <= w_mcand;
                        r_m_mplier <= w_mplier;
                        r_cnt      <= '0;
                    end
                end
                ISSUE: r_cnt <= r_cnt + 1'b1;
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (m_done) begin
                        r_product <= m_product;
                    end
                end
                RESP: begin
                    r_rr_ptr <= (r_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt            = r_gnt;
    assign resp_valid     = r_resp_valid;
    assign resp_err       = r_resp_err;
    assign product_o      = r_product;
    assign busy           = r_busy;
    assign m_start        = r_m_start;
    assign m_multiplicand = r_m_mcand;
    assign m_multiplier   = r_m_mplier;

endmodule
